// File: rtl/snax_hwpe_regs_pkg.sv
// rtl/snax_hwpe_regs_pkg.sv - register map constants and helpers for the HWPE periph register file
package snax_hwpe_regs_pkg;

    localparam logic [5:0] IDX_CMD    = 6'd0;
    localparam logic [5:0] IDX_STATUS = 6'd1;
    localparam logic [5:0] IDX_JOBCNT = 6'd2;
    localparam int         CFG_BASE   = 3;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_CLEAR_BIT = 1;

    localparam int STATUS_BUSY_BIT       = 0;
    localparam int STATUS_START_DROP_BIT = 1;
    localparam int STATUS_CFG_LOCK_BIT   = 2;

    localparam logic [31:0] RDATA_DEFAULT = 32'h0000_0000;

    // Byte-lane merge: lanes with be set take the new data, others keep the old value.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b+:8] = be[b] ? new_v[8*b+:8] : old_v[8*b+:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/snax_hwpe_be_reg.sv
// rtl/snax_hwpe_be_reg.sv - 32-bit byte-enabled register with synchronous clear
module snax_hwpe_be_reg
    import snax_hwpe_regs_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic [31:0] q_o
);

    logic [31:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (we_i) begin
            q_d = be_merge(q_q, data_i, be_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/snax_hwpe_periph_regs.sv
// rtl/snax_hwpe_periph_regs.sv - periph responder decoding requests into the accelerator register file
module snax_hwpe_periph_regs
    import snax_hwpe_regs_pkg::*;
#(
    parameter int NumCfgRegs = 4,
    parameter int IdWidth    = 5,
    parameter int CntWidth   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       periph_req_i,
    output logic                       periph_gnt_o,
    input  logic [31:0]                periph_add_i,
    input  logic                       periph_wen_i,
    input  logic [3:0]                 periph_be_i,
    input  logic [31:0]                periph_data_i,
    input  logic [IdWidth-1:0]         periph_id_i,
    output logic [31:0]                periph_r_data_o,
    output logic                       periph_r_valid_o,
    output logic [IdWidth-1:0]         periph_r_id_o,
    output logic [NumCfgRegs*32-1:0]   cfg_o,
    output logic                       start_o,
    output logic                       busy_o,
    input  logic                       done_i
);

    logic [5:0]         idx;
    logic               unused_add;
    logic               gnt, rd_en, wr_en, be_any;
    logic               cmd_wr, status_wr, jobcnt_wr, cfg_wr;
    logic               start_req, soft_clr, start_acc;
    logic [31:0]        status_w, rdata;
    logic [31:0]        cfg_q [NumCfgRegs];

    logic               r_valid_q;
    logic [31:0]        r_data_q;
    logic [IdWidth-1:0] r_id_q;
    logic               start_q;
    logic               busy_d, busy_q;
    logic               start_drop_d, start_drop_q;
    logic               cfg_lock_err_d, cfg_lock_err_q;
    logic [CntWidth-1:0] jobcnt_d, jobcnt_q;

    assign idx        = periph_add_i[7:2];
    assign unused_add = ^{periph_add_i[31:8], periph_add_i[1:0]};

    // No grant while a read response is on the bus, so a held read is accepted only once.
    assign gnt    = periph_req_i & ~r_valid_q;
    assign rd_en  = gnt & periph_wen_i;
    assign wr_en  = gnt & ~periph_wen_i;
    assign be_any = |periph_be_i;

    assign cmd_wr    = wr_en & be_any & (idx == IDX_CMD);
    assign status_wr = wr_en & be_any & (idx == IDX_STATUS);
    assign jobcnt_wr = wr_en & (idx == IDX_JOBCNT);
    assign cfg_wr    = wr_en & (int'(idx) >= CFG_BASE) & (int'(idx) < CFG_BASE + NumCfgRegs);

    assign start_req = cmd_wr & periph_data_i[CMD_START_BIT];
    assign soft_clr  = cmd_wr & periph_data_i[CMD_CLEAR_BIT];
    assign start_acc = start_req & (~busy_q | done_i) & ~soft_clr;

    for (genvar i = 0; i < NumCfgRegs; i++) begin : g_cfg
        snax_hwpe_be_reg u_cfg (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (soft_clr),
            .we_i   (cfg_wr & ~busy_q & (int'(idx) == CFG_BASE + i)),
            .be_i   (periph_be_i),
            .data_i (periph_data_i),
            .q_o    (cfg_q[i])
        );
        assign cfg_o[32*i+:32] = cfg_q[i];
    end

    always_comb begin
        status_w = '0;
        status_w[STATUS_BUSY_BIT]       = busy_q;
        status_w[STATUS_START_DROP_BIT] = start_drop_q;
        status_w[STATUS_CFG_LOCK_BIT]   = cfg_lock_err_q;
    end

    always_comb begin
        rdata = RDATA_DEFAULT;
        case (idx)
            IDX_CMD:    rdata = '0;
            IDX_STATUS: rdata = status_w;
            IDX_JOBCNT: rdata = 32'(jobcnt_q);
            default: begin
                for (int i = 0; i < NumCfgRegs; i++) begin
                    if (int'(idx) == CFG_BASE + i) rdata = cfg_q[i];
                end
            end
        endcase
    end

    always_comb begin
        busy_d         = soft_clr ? 1'b0 : (start_acc | (busy_q & ~done_i));
        start_drop_d   = start_drop_q;
        cfg_lock_err_d = cfg_lock_err_q;
        if (soft_clr || status_wr) begin
            start_drop_d   = 1'b0;
            cfg_lock_err_d = 1'b0;
        end else begin
            if (start_req && busy_q && !done_i) start_drop_d = 1'b1;
            if (cfg_wr && busy_q)               cfg_lock_err_d = 1'b1;
        end

        // A register write in the same cycle as done_i overrides the increment.
        jobcnt_d = jobcnt_q;
        if (soft_clr) begin
            jobcnt_d = '0;
        end else if (jobcnt_wr) begin
            jobcnt_d = CntWidth'(be_merge(32'(jobcnt_q), periph_data_i, periph_be_i));
        end else if (done_i && busy_q) begin
            jobcnt_d = jobcnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q      <= 1'b0;
            r_data_q       <= '0;
            r_id_q         <= '0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            start_drop_q   <= 1'b0;
            cfg_lock_err_q <= 1'b0;
            jobcnt_q       <= '0;
        end else begin
            r_valid_q <= rd_en;
            if (rd_en) begin
                r_data_q <= rdata;
                r_id_q   <= periph_id_i;
            end
            start_q        <= start_acc;
            busy_q         <= busy_d;
            start_drop_q   <= start_drop_d;
            cfg_lock_err_q <= cfg_lock_err_d;
            jobcnt_q       <= jobcnt_d;
        end
    end

    assign periph_gnt_o     = gnt;
    assign periph_r_valid_o = r_valid_q;
    assign periph_r_data_o  = r_data_q;
    assign periph_r_id_o    = r_id_q;
    assign start_o          = start_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_snax_hwpe_periph_regs.sv
// tb/tb_snax_hwpe_periph_regs.sv - directed self-checking bench for snax_hwpe_periph_regs
module tb_snax_hwpe_periph_regs;

    localparam int NumCfgRegs = 4;
    localparam int IdWidth    = 5;
    localparam int CntWidth   = 16;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     periph_req_i = 1'b0;
    logic                     periph_gnt_o;
    logic [31:0]              periph_add_i = '0;
    logic                     periph_wen_i = 1'b0;
    logic [3:0]               periph_be_i = '0;
    logic [31:0]              periph_data_i = '0;
    logic [IdWidth-1:0]       periph_id_i = '0;
    logic [31:0]              periph_r_data_o;
    logic                     periph_r_valid_o;
    logic [IdWidth-1:0]       periph_r_id_o;
    logic [NumCfgRegs*32-1:0] cfg_o;
    logic                     start_o;
    logic                     busy_o;
    logic                     done_i = 1'b0;

    int tests = 0;
    int failed = 0;

    snax_hwpe_periph_regs #(
        .NumCfgRegs (NumCfgRegs),
        .IdWidth    (IdWidth),
        .CntWidth   (CntWidth)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .periph_req_i     (periph_req_i),
        .periph_gnt_o     (periph_gnt_o),
        .periph_add_i     (periph_add_i),
        .periph_wen_i     (periph_wen_i),
        .periph_be_i      (periph_be_i),
        .periph_data_i    (periph_data_i),
        .periph_id_i      (periph_id_i),
        .periph_r_data_o  (periph_r_data_o),
        .periph_r_valid_o (periph_r_valid_o),
        .periph_r_id_o    (periph_r_id_o),
        .cfg_o            (cfg_o),
        .start_o          (start_o),
        .busy_o           (busy_o),
        .done_i           (done_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One-cycle write: inputs set after a negedge, effects sampled at the next negedge.
    task automatic wr(input logic [31:0] add, input logic [31:0] data, input logic [3:0] be);
        periph_req_i  = 1'b1;
        periph_wen_i  = 1'b0;
        periph_add_i  = add;
        periph_data_i = data;
        periph_be_i   = be;
        #1;
        chk("wr_gnt", 32'(periph_gnt_o), 32'd1);
        @(negedge clk_i);
        periph_req_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] add, input logic [IdWidth-1:0] id,
                      input logic [31:0] exp);
        periph_req_i = 1'b1;
        periph_wen_i = 1'b1;
        periph_add_i = add;
        periph_id_i  = id;
        periph_be_i  = '0;
        #1;
        chk({tag, "_gnt"}, 32'(periph_gnt_o), 32'd1);
        @(negedge clk_i);
        periph_req_i = 1'b0;
        chk({tag, "_rvalid"}, 32'(periph_r_valid_o), 32'd1);
        chk({tag, "_rid"}, 32'(periph_r_id_o), 32'(id));
        chk({tag, "_rdata"}, periph_r_data_o, exp);
        @(negedge clk_i);
        chk({tag, "_rvalid_low"}, 32'(periph_r_valid_o), 32'd0);
    endtask

    initial begin
        int gnt_cnt;
        int rv_cnt;

        repeat (2) @(negedge clk_i);
        chk("rst_rvalid", 32'(periph_r_valid_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cfg_zero", 32'(cfg_o == '0), 32'd1);
        chk("rst_gnt", 32'(periph_gnt_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        rd("status0", 32'h04, 5'd3, 32'h0);

        // Held read: request stays high through the response cycle.
        gnt_cnt = 0;
        rv_cnt  = 0;
        periph_req_i = 1'b1;
        periph_wen_i = 1'b1;
        periph_add_i = 32'h08;
        periph_id_i  = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (periph_gnt_o) gnt_cnt++;
            @(negedge clk_i);
            if (periph_r_valid_o) rv_cnt++;
            if (c == 1) periph_req_i = 1'b0;
        end
        chk("held_gnt_cnt", 32'(gnt_cnt), 32'd1);
        chk("held_rv_cnt", 32'(rv_cnt), 32'd1);

        wr(32'h0C, 32'hA5A5_A5A5, 4'b0101);
        chk("cfg0_be", cfg_o[31:0], 32'h00A5_00A5);
        rd("cfg0_rb", 32'h0C, 5'd1, 32'h00A5_00A5);
        rd("cfg0_rb_ignored_bits", 32'hFFFF_FF0F, 5'd2, 32'h00A5_00A5);

        wr(32'h00, 32'h1, 4'hF);
        chk("start_pulse", 32'(start_o), 32'd1);
        chk("start_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        chk("start_pulse_end", 32'(start_o), 32'd0);

        wr(32'h00, 32'h1, 4'hF);
        chk("drop_no_start", 32'(start_o), 32'd0);
        rd("status_drop", 32'h04, 5'd4, 32'h3);
        wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        rd("status_lock", 32'h04, 5'd5, 32'h7);
        chk("cfg0_locked", cfg_o[31:0], 32'h00A5_00A5);

        // Start and done together while busy: restart accepted, one job counted.
        done_i = 1'b1;
        wr(32'h00, 32'h1, 4'hF);
        done_i = 1'b0;
        chk("restart_pulse", 32'(start_o), 32'd1);
        chk("restart_busy", 32'(busy_o), 32'd1);
        rd("jobcnt1", 32'h08, 5'd6, 32'h1);

        wr(32'h04, 32'h0, 4'hF);
        rd("status_cleared", 32'h04, 5'd8, 32'h1);

        wr(32'h08, 32'h0000_FFFF, 4'hF);
        done_i = 1'b1;
        @(negedge clk_i);
        done_i = 1'b0;
        chk("done_busy_low", 32'(busy_o), 32'd0);
        rd("jobcnt_wrap", 32'h08, 5'd9, 32'h0);
        wr(32'h08, 32'h1234_5678, 4'b0001);
        rd("jobcnt_be", 32'h08, 5'd10, 32'h78);

        wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
        rd("oor_read", 32'h1C, 5'd11, 32'h0);
        rd("oor_status", 32'h04, 5'd12, 32'h0);
        rd("cmd_read", 32'h00, 5'd13, 32'h0);

        wr(32'h18, 32'hDEAD_BEEF, 4'hF);
        chk("cfg3_write", cfg_o[127:96], 32'hDEAD_BEEF);
        wr(32'h00, 32'h1, 4'hF);
        chk("busy_before_clear", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        wr(32'h00, 32'h3, 4'hF);
        chk("clear_no_start", 32'(start_o), 32'd0);
        chk("clear_busy", 32'(busy_o), 32'd0);
        chk("clear_cfg", 32'(cfg_o == '0), 32'd1);
        rd("clear_jobcnt", 32'h08, 5'd14, 32'h0);

        // Reset asserted while a granted read is waiting for its clock edge.
        rv_cnt = 0;
        periph_req_i = 1'b1;
        periph_wen_i = 1'b1;
        periph_add_i = 32'h0C;
        periph_id_i  = 5'd15;
        #1;
        chk("pend_gnt", 32'(periph_gnt_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            if (periph_r_valid_o) rv_cnt++;
            if (c == 0) periph_req_i = 1'b0;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        if (periph_r_valid_o) rv_cnt++;
        chk("rst_pending_rv", 32'(rv_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
